// File: rtl/im_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : im_seq_pkg
//  Description : Shared definitions for the instruction sequencer: opcode
//                values, FSM state encoding, instruction field positions,
//                the WAIT_ALU timeout default and small field-extract helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package im_seq_pkg;

    localparam int INSTR_W         = 18;
    localparam int OP_W            = 3;
    localparam int REG_W           = 5;

    // Instruction layout: {op[17:15], dst[14:10], srca[9:5], srcb[4:0]}
    localparam int OP_LSB          = 15;
    localparam int DST_LSB         = 10;
    localparam int SRCA_LSB        = 5;
    localparam int SRCB_LSB        = 0;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [OP_W-1:0]    op_t;
    typedef logic [REG_W-1:0]   reg_idx_t;

    localparam op_t OP_NOP   = 3'd0;
    localparam op_t OP_LOAD  = 3'd1;
    localparam op_t OP_MOV   = 3'd2;
    localparam op_t OP_ALUC  = 3'd3;
    localparam op_t OP_ALUF  = 3'd4;
    localparam op_t OP_ALUCF = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DECODE   = 3'd1,
        ST_READ     = 3'd2,
        ST_WAIT_ALU = 3'd3,
        ST_WB1      = 3'd4,
        ST_WB2      = 3'd5
    } state_e;

    function automatic op_t instr_op(input instr_t i);
        return i[OP_LSB +: OP_W];
    endfunction

    function automatic reg_idx_t instr_dst(input instr_t i);
        return i[DST_LSB +: REG_W];
    endfunction

    function automatic reg_idx_t instr_srca(input instr_t i);
        return i[SRCA_LSB +: REG_W];
    endfunction

    function automatic reg_idx_t instr_srcb(input instr_t i);
        return i[SRCB_LSB +: REG_W];
    endfunction

    function automatic logic op_is_alu(input op_t op);
        return (op == OP_ALUC) || (op == OP_ALUF) || (op == OP_ALUCF);
    endfunction

    function automatic logic op_is_illegal(input op_t op);
        return op > OP_ALUCF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/im_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : im_seq_if
//  Description : Bundle of the sequencer's instruction handshake, ALU
//                handshake and register-file / databus control signals.
//                master : instruction source, ALU and register-file side
//                slave  : the sequencer itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface im_seq_if;
    import im_seq_pkg::*;

    logic     instr_valid;
    logic     instr_ready;
    instr_t   instr;
    logic     alu_start;
    logic     alu_done;
    reg_idx_t a_sel;
    reg_idx_t b_sel;
    logic     rd;
    reg_idx_t rd_sel;
    logic     wr;
    reg_idx_t wr_sel;
    logic     ld_en;
    logic     c_en;
    logic     f_en;
    logic     busy;
    logic     err;

    modport master (
        output instr_valid, instr, alu_done,
        input  instr_ready, alu_start, a_sel, b_sel, rd, rd_sel,
               wr, wr_sel, ld_en, c_en, f_en, busy, err
    );

    modport slave (
        input  instr_valid, instr, alu_done,
        output instr_ready, alu_start, a_sel, b_sel, rd, rd_sel,
               wr, wr_sel, ld_en, c_en, f_en, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/im_seq_timer.sv
`default_nettype none
// ============================================================================
//  Module      : im_seq_timer
//  Description : Counts cycles spent in WAIT_ALU. The count is held at zero
//                whenever the FSM is outside WAIT_ALU, so it starts fresh on
//                every entry. expired is high during the TIMEOUT-th cycle.
//  Ports       : clk, rst_n  - clock, async active-low reset
//                run         - FSM is in WAIT_ALU this cycle
//                expired     - this is the last permitted WAIT_ALU cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module im_seq_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired
);
    import im_seq_pkg::*;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = run && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (run) begin
            // Saturate at the limit; the FSM leaves WAIT_ALU on expiry anyway.
            cnt_d = expired ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/im_seq.sv
`default_nettype none
// ============================================================================
//  Module      : im_seq
//  Description : Instruction sequencer driving a register file, a shared
//                databus and an ALU. Accepts one 18-bit instruction at a time
//                (NOP/LOAD/MOV/ALUC/ALUF/ALUCF) and walks it through
//                DECODE -> READ | WAIT_ALU -> WB1 -> WB2.
//  Ports       : clk, rst_n - clock, async active-low reset
//                bus        - im_seq_if.slave: instruction handshake,
//                             ALU start/done, operand selects, register-file
//                             rd/wr controls, databus enables, busy, err
//  Revision    : 1.0 - initial release
// ============================================================================
module im_seq #(
    parameter int TIMEOUT = im_seq_pkg::TIMEOUT_DEFAULT
) (
    input  logic    clk,
    input  logic    rst_n,
    im_seq_if.slave bus
);
    import im_seq_pkg::*;

    state_e   state_q, state_d;
    instr_t   instr_q, instr_d;
    op_t      next_op;
    logic     timeout_err;
    logic     in_wait;
    logic     tmr_expired;

    logic     instr_ready_q, instr_ready_d;
    logic     busy_q, busy_d;
    logic     alu_start_q, alu_start_d;
    logic     err_q, err_d;
    logic     rd_q, rd_d;
    logic     wr_q, wr_d;
    logic     ld_en_q, ld_en_d;
    logic     c_en_q, c_en_d;
    logic     f_en_q, f_en_d;
    reg_idx_t a_sel_q, a_sel_d;
    reg_idx_t b_sel_q, b_sel_d;
    reg_idx_t rd_sel_q, rd_sel_d;
    reg_idx_t wr_sel_q, wr_sel_d;

    assign in_wait = (state_q == ST_WAIT_ALU);

    im_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (in_wait),
        .expired (tmr_expired)
    );

    // Next-state logic. alu_done is only looked at in WAIT_ALU.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        timeout_err = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    state_d = ST_DECODE;
                    instr_d = bus.instr;
                end
            end
            ST_DECODE: begin
                case (instr_op(instr_q))
                    OP_LOAD:                     state_d = ST_WB1;
                    OP_MOV:                      state_d = ST_READ;
                    OP_ALUC, OP_ALUF, OP_ALUCF:  state_d = ST_WAIT_ALU;
                    default:                     state_d = ST_IDLE;
                endcase
            end
            ST_WAIT_ALU: begin
                if (bus.alu_done) begin
                    state_d = ST_WB1;
                end else if (tmr_expired) begin
                    state_d     = ST_IDLE;
                    timeout_err = 1'b1;
                end
            end
            ST_READ: state_d = ST_IDLE;
            ST_WB1:  state_d = (instr_op(instr_q) == OP_ALUCF) ? ST_WB2 : ST_IDLE;
            ST_WB2:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that, once registered, they
    // line up exactly with the state they belong to. instr_d already holds
    // the instruction being accepted, so DECODE-cycle outputs are available.
    always_comb begin
        next_op       = instr_op(instr_d);
        instr_ready_d = (state_d == ST_IDLE);
        busy_d        = (state_d != ST_IDLE);
        alu_start_d   = (state_d == ST_DECODE) && op_is_alu(next_op);
        err_d         = timeout_err ||
                        ((state_d == ST_DECODE) && op_is_illegal(next_op));
        a_sel_d       = busy_d ? instr_srca(instr_d) : '0;
        b_sel_d       = busy_d ? instr_srcb(instr_d) : '0;
        rd_d          = (state_d == ST_READ);
        rd_sel_d      = rd_d ? instr_srca(instr_d) : '0;
        wr_d          = (state_d == ST_READ) || (state_d == ST_WB1) ||
                        (state_d == ST_WB2);
        wr_sel_d      = '0;
        if ((state_d == ST_READ) || (state_d == ST_WB1)) begin
            wr_sel_d = instr_dst(instr_d);
        end else if (state_d == ST_WB2) begin
            wr_sel_d = instr_dst(instr_d) + 5'd1;   // wraps 31 -> 0
        end
        ld_en_d       = (state_d == ST_WB1) && (next_op == OP_LOAD);
        c_en_d        = (state_d == ST_WB1) &&
                        ((next_op == OP_ALUC) || (next_op == OP_ALUCF));
        f_en_d        = ((state_d == ST_WB1) && (next_op == OP_ALUF)) ||
                        (state_d == ST_WB2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            instr_q       <= '0;
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            alu_start_q   <= 1'b0;
            err_q         <= 1'b0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            ld_en_q       <= 1'b0;
            c_en_q        <= 1'b0;
            f_en_q        <= 1'b0;
            a_sel_q       <= '0;
            b_sel_q       <= '0;
            rd_sel_q      <= '0;
            wr_sel_q      <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_ready_q <= instr_ready_d;
            busy_q        <= busy_d;
            alu_start_q   <= alu_start_d;
            err_q         <= err_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            ld_en_q       <= ld_en_d;
            c_en_q        <= c_en_d;
            f_en_q        <= f_en_d;
            a_sel_q       <= a_sel_d;
            b_sel_q       <= b_sel_d;
            rd_sel_q      <= rd_sel_d;
            wr_sel_q      <= wr_sel_d;
        end
    end

    assign bus.instr_ready = instr_ready_q;
    assign bus.busy        = busy_q;
    assign bus.alu_start   = alu_start_q;
    assign bus.err         = err_q;
    assign bus.rd          = rd_q;
    assign bus.rd_sel      = rd_sel_q;
    assign bus.wr          = wr_q;
    assign bus.wr_sel      = wr_sel_q;
    assign bus.ld_en       = ld_en_q;
    assign bus.c_en        = c_en_q;
    assign bus.f_en        = f_en_q;
    assign bus.a_sel       = a_sel_q;
    assign bus.b_sel       = b_sel_q;
endmodule
`default_nettype wire

// File: tb/tb_im_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_im_seq
//  Description : Randomized self-checking bench for im_seq. A driver issues
//                instructions and pushes the expected output events (cycle,
//                flags, indices) into a scoreboard queue; a monitor pops and
//                compares whenever the sequencer shows any activity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_im_seq;

    localparam int TO = 15;

    typedef struct {
        int       cyc;
        bit       alu_start;
        bit       err;
        bit       rd;
        bit [4:0] rd_sel;
        bit       wr;
        bit [4:0] wr_sel;
        bit       ld;
        bit       c;
        bit       f;
        bit       chk_sel;
        bit [4:0] a_sel;
        bit [4:0] b_sel;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    ev_t  sbq[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   mon_en = 0;
    int   i_idle = 0;

    // Busy intervals and WAIT_ALU windows of the current and previous instr.
    int cur_blo = 0, cur_bhi = -1, prev_blo = 0, prev_bhi = -1;
    int cur_wlo = 0, cur_whi = -1, cur_done = -1;
    int prev_wlo = 0, prev_whi = -1, prev_done = -1;

    im_seq_if bus();

    im_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic ev_t mk(input int c);
        ev_t e;
        e = '{default: 0};
        e.cyc = c;
        return e;
    endfunction

    function automatic logic done_for(input int c);
        if (c >= cur_wlo && c <= cur_whi) return (c == cur_done);
        if (c >= prev_wlo && c <= prev_whi) return (c == prev_done);
        return ($urandom_range(0, 3) == 0);   // stray alu_done outside WAIT_ALU
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        bus.alu_done = done_for(cyc);
    endtask

    task automatic clear_ranges();
        cur_blo = 0; cur_bhi = -1; prev_blo = 0; prev_bhi = -1;
        cur_wlo = 0; cur_whi = -1; cur_done = -1;
        prev_wlo = 0; prev_whi = -1; prev_done = -1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, int'(bus.instr_ready), 1);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_ctrl"}, int'({bus.rd, bus.wr, bus.ld_en, bus.c_en, bus.f_en,
                                  bus.alu_start, bus.err}), 0);
        chk({tag, "_sels"}, int'({bus.rd_sel, bus.wr_sel, bus.a_sel, bus.b_sel}), 0);
    endtask

    // Reference model: from the opcode and ALU wait N, derive every visible
    // event and when the sequencer is idle again. 'early' raises instr_valid
    // up to that many cycles before the sequencer is free.
    task automatic issue(input int op, input int dst, input int sa, input int sb,
                         input int n, input int early);
        int  cur, a, ws, e, t;
        ev_t ev;
        cur = cyc;
        a   = ((cur > i_idle) ? cur : i_idle) + 1;
        ws  = i_idle - early;
        if (ws < cur) ws = cur;
        prev_blo = cur_blo; prev_bhi = cur_bhi;
        prev_wlo = cur_wlo; prev_whi = cur_whi; prev_done = cur_done;
        cur_wlo = 0; cur_whi = -1; cur_done = -1;
        case (op)
            0: e = a + 1;
            1: begin
                ev = mk(a + 1); ev.wr = 1; ev.wr_sel = 5'(dst); ev.ld = 1;
                sbq.push_back(ev); e = a + 2;
            end
            2: begin
                ev = mk(a + 1); ev.rd = 1; ev.rd_sel = 5'(sa);
                ev.wr = 1; ev.wr_sel = 5'(dst);
                sbq.push_back(ev); e = a + 2;
            end
            3, 4, 5: begin
                ev = mk(a); ev.alu_start = 1;
                ev.chk_sel = 1; ev.a_sel = 5'(sa); ev.b_sel = 5'(sb);
                sbq.push_back(ev);
                cur_wlo = a + 1;
                if (n < TO) begin
                    cur_done = a + 1 + n; cur_whi = cur_done; t = a + 2 + n;
                    ev = mk(t); ev.wr = 1; ev.wr_sel = 5'(dst);
                    ev.c = (op != 4); ev.f = (op == 4);
                    ev.chk_sel = 1; ev.a_sel = 5'(sa); ev.b_sel = 5'(sb);
                    sbq.push_back(ev);
                    if (op == 5) begin
                        ev = mk(t + 1); ev.wr = 1; ev.wr_sel = 5'((dst + 1) % 32); ev.f = 1;
                        ev.chk_sel = 1; ev.a_sel = 5'(sa); ev.b_sel = 5'(sb);
                        sbq.push_back(ev); e = t + 2;
                    end else begin
                        e = t + 1;
                    end
                end else begin
                    cur_whi = a + TO;
                    ev = mk(a + TO + 1); ev.err = 1;
                    sbq.push_back(ev); e = a + TO + 1;
                end
            end
            default: begin
                ev = mk(a); ev.err = 1; sbq.push_back(ev); e = a + 1;
            end
        endcase
        cur_blo = a; cur_bhi = e - 1;
        while (cyc < ws) step();
        bus.instr_valid = 1'b1;
        bus.instr = {3'(op), 5'(dst), 5'(sa), 5'(sb)};
        while (cyc < a) step();
        bus.instr_valid = 1'b0;
        bus.instr = 18'($urandom);
        i_idle = e;
    endtask

    // Monitor / scoreboard checker.
    always @(negedge clk) begin
        ev_t ev;
        bit  exp_busy;
        int  nen;
        if (mon_en) begin
            exp_busy = (cyc >= cur_blo && cyc <= cur_bhi) ||
                       (cyc >= prev_blo && cyc <= prev_bhi);
            chk("busy", int'(bus.busy), int'(exp_busy));
            chk("instr_ready", int'(bus.instr_ready), int'(!exp_busy));
            nen = int'(bus.ld_en) + int'(bus.c_en) + int'(bus.f_en);
            chk("enable_exclusive", int'((nen > 1) || (bus.rd && nen != 0)), 0);
            if (bus.alu_start || bus.err || bus.rd || bus.wr ||
                bus.ld_en || bus.c_en || bus.f_en) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    ev = sbq.pop_front();
                    chk("event_cycle", cyc, ev.cyc);
                    chk("ctrl_flags",
                        int'({bus.alu_start, bus.err, bus.rd, bus.wr, bus.ld_en, bus.c_en, bus.f_en}),
                        int'({ev.alu_start, ev.err, ev.rd, ev.wr, ev.ld, ev.c, ev.f}));
                    if (ev.rd) chk("rd_sel", int'(bus.rd_sel), int'(ev.rd_sel));
                    if (ev.wr) chk("wr_sel", int'(bus.wr_sel), int'(ev.wr_sel));
                    if (ev.chk_sel) begin
                        chk("a_sel", int'(bus.a_sel), int'(ev.a_sel));
                        chk("b_sel", int'(bus.b_sel), int'(ev.b_sel));
                    end
                end
            end
        end
    end

    initial begin
        rst_n           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.alu_done    = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_reset("reset");
        repeat (3) step();
        rst_n  = 1'b1;
        i_idle = cyc;
        mon_en = 1'b1;

        // Directed corner cases.
        issue(1, 7, 0, 0, 0, 0);      // LOAD dst=7
        issue(2, 3, 9, 4, 0, 2);      // MOV dst=3 <- 9, valid held while busy
        issue(5, 31, 5, 6, 2, 1);     // ALUCF dst=31, done after 2 cycles
        issue(3, 10, 1, 2, 99, 0);    // ALUC, alu_done never comes
        issue(6, 1, 2, 3, 0, 3);      // illegal opcode, held across the timeout
        issue(4, 0, 8, 9, 0, 0);      // ALUF, done on WAIT_ALU entry
        issue(3, 2, 3, 4, TO - 1, 0); // done in the last permitted cycle
        issue(5, 12, 7, 1, TO, 0);    // done one cycle too late
        issue(0, 4, 4, 4, 0, 1);      // NOP
        issue(7, 9, 9, 9, 0, 0);      // illegal opcode 7

        for (int k = 0; k < 200; k++) begin
            int op, n, r;
            op = int'($urandom_range(0, 7));
            r  = int'($urandom_range(0, 7));
            n  = (r < 5) ? int'($urandom_range(0, 3)) :
                 (r == 5) ? TO - 1 : (r == 6) ? TO : int'($urandom_range(16, 25));
            if ($urandom_range(0, 3) == 0) step();
            issue(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), n, int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in the middle of WAIT_ALU.
        issue(3, 5, 6, 7, 99, 0);
        repeat (3) step();
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_reset("async_reset");
        sbq.delete();
        clear_ranges();
        repeat (2) step();
        rst_n  = 1'b1;
        i_idle = cyc;
        mon_en = 1'b1;
        repeat (20) step();

        issue(1, 30, 0, 0, 0, 0);     // sequencer still works after reset
        repeat (4) step();
        chk("scoreboard_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
